// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Round-robin arbiter for MASTER_CH (fixed at 4) bus masters with
//   release-driven handover, hold-time preemption and an atomic Lock
//   qualifier.
//
// Parameters
//   MASTER_CH  number of masters (4, so Owner is 2 bits)
//   MAX_HOLD   owned cycles before preemption, 0 disables (0..255)
//
// Ports
//   clk      rising-edge clock
//   reset_   asynchronous active-low reset
//   Req      per-master level request, held for the whole transfer
//   Lock     current owner asks not to be preempted
//   Grant    registered one-hot grant, or all-zero
//   Owner    registered index of the granted master, sticky when idle
//   BusBusy  registered, high exactly when Grant is nonzero
//   Preempt  registered one-cycle pulse on a forced ownership change
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int MASTER_CH = 4,
    parameter int MAX_HOLD  = 16
) (
    input  logic                         clk,
    input  logic                         reset_,
    input  logic [MASTER_CH-1:0]         Req,
    input  logic                         Lock,
    output logic [MASTER_CH-1:0]         Grant,
    output logic [$clog2(MASTER_CH)-1:0] Owner,
    output logic                         BusBusy,
    output logic                         Preempt
);

    localparam int       OW         = $clog2(MASTER_CH);
    localparam bit       PREEMPT_EN = (MAX_HOLD != 0);
    localparam bit [7:0] HOLD_LIM   = 8'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t               state_q;
    logic [MASTER_CH-1:0] grant_q;
    logic [OW-1:0]        owner_q;
    logic [OW-1:0]        last_q;
    logic [7:0]           hold_q;
    logic                 busy_q;
    logic                 preempt_q;

    // Arbitration result for this cycle
    logic [MASTER_CH-1:0] cand;
    logic [MASTER_CH-1:0] win_oh;
    logic [OW-1:0]        win;
    logic [OW-1:0]        idx;
    logic                 found;
    logic                 preempt_cond;

    // While owned, the owner is excluded: the result is only used on
    // release or preemption, both of which must pick someone else.
    // The search starts at last_q+1; last_q equals owner_q while owned.
    always_comb begin
        cand = Req;
        if (state_q == OWNED) begin
            cand[owner_q] = 1'b0;
        end
        found  = 1'b0;
        win    = '0;
        idx    = '0;
        win_oh = '0;
        for (int unsigned i = 1; i <= MASTER_CH; i++) begin
            idx = last_q + OW'(i);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (found) begin
            win_oh[win] = 1'b1;
        end
    end

    // >= rather than == so that a limit reached while alone (or locked)
    // still preempts as soon as a competitor shows up or Lock drops.
    assign preempt_cond = PREEMPT_EN && (hold_q >= HOLD_LIM) && !Lock;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            last_q    <= OW'(MASTER_CH - 1);
            hold_q    <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q <= OWNED;
                        grant_q <= win_oh;
                        owner_q <= win;
                        last_q  <= win;
                        hold_q  <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                OWNED: begin
                    if (!Req[owner_q]) begin
                        // Release wins over any simultaneous preemption
                        if (found) begin
                            grant_q <= win_oh;
                            owner_q <= win;
                            last_q  <= win;
                            hold_q  <= '0;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                        end
                    end else if (preempt_cond && found) begin
                        grant_q   <= win_oh;
                        owner_q   <= win;
                        last_q    <= win;
                        hold_q    <= '0;
                        preempt_q <= 1'b1;
                    end else if (hold_q != 8'hFF) begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Grant   = grant_q;
    assign Owner   = owner_q;
    assign BusBusy = busy_q;
    assign Preempt = preempt_q;

endmodule
